// File: rtl/ins_fetch_queue.sv
// Fetch-side producer: fetches at pc, predicts next pc, and buffers {ins, pc, pred_taken, bht_id} for decode.
// Latency: fetch_done at cycle N with an empty queue gives deq_valid at N+1; bht_id1 is combinational from pc.
// Backpressure: fetch_req drops once the queue is full; rdy=0 freezes every register; flush empties and redirects.
module ins_fetch_queue #(
    parameter int DEPTH     = 16,
    parameter int BHT_IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    output logic                 fetch_req,
    output logic [31:0]          fetch_pc,
    input  logic                 fetch_done,
    input  logic [31:0]          fetch_ins,
    output logic [BHT_IDX_W-1:0] bht_id1,
    input  logic                 bht_get,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [31:0]          deq_ins,
    output logic [31:0]          deq_pc,
    output logic                 deq_pred_taken,
    output logic [BHT_IDX_W-1:0] deq_bht_id,
    input  logic                 flush,
    input  logic [31:0]          flush_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0]          ins;
        logic [31:0]          pc;
        logic                 pred_taken;
        logic [BHT_IDX_W-1:0] bht_id;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    logic               wr_en;

    logic               enq;
    logic               deq;
    logic [31:0]        imm_b;
    logic [31:0]        imm_j;
    logic [31:0]        next_pc;
    logic               pred_taken;

    assign fetch_req      = (state_q == S_WAIT);
    assign fetch_pc       = pc_q;
    assign bht_id1        = pc_q[BHT_IDX_W+1:2];
    assign deq_valid      = (count_q != '0);
    assign deq_ins        = mem_q[head_q].ins;
    assign deq_pc         = mem_q[head_q].pc;
    assign deq_pred_taken = mem_q[head_q].pred_taken;
    assign deq_bht_id     = mem_q[head_q].bht_id;

    assign enq = (state_q == S_WAIT) && fetch_done;
    assign deq = (count_q != '0) && deq_ready;

    // Static predictor: branches follow the BHT, JAL is always taken, everything else (JALR too) falls through.
    always_comb begin
        imm_b      = {{19{fetch_ins[31]}}, fetch_ins[31], fetch_ins[7], fetch_ins[30:25],
                      fetch_ins[11:8], 1'b0};
        imm_j      = {{11{fetch_ins[31]}}, fetch_ins[31], fetch_ins[19:12], fetch_ins[20],
                      fetch_ins[30:21], 1'b0};
        next_pc    = pc_q + 32'd4;
        pred_taken = 1'b0;
        if (fetch_ins[6:0] == OP_BRANCH) begin
            pred_taken = bht_get;
            if (bht_get) begin
                next_pc = pc_q + imm_b;
            end
        end else if (fetch_ins[6:0] == OP_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc_q + imm_j;
        end
        wr_entry = '{ins: fetch_ins, pc: pc_q, pred_taken: pred_taken, bht_id: bht_id1};
    end

    // Next-state: flush beats normal operation; rdy=0 leaves every _d equal to its _q.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (rdy) begin
            if (flush) begin
                state_d = S_IDLE;
                pc_d    = flush_pc;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (enq) begin
                    wr_en  = 1'b1;
                    tail_d = tail_q + PTR_W'(1);
                    pc_d   = next_pc;
                end
                if (deq) begin
                    head_d = head_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
                case (state_q)
                    S_IDLE: begin
                        if (count_q < DEPTH_C) begin
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // WAIT is only entered with a free slot, so one enqueue can at most fill the queue.
                        if (enq && !(count_d < DEPTH_C)) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because deq_* are ignored while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
module tb_ins_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_done = 1'b0;
    logic [31:0] fetch_ins = '0;
    logic [7:0]  bht_id1;
    logic        bht_get = 1'b0;
    logic        deq_valid;
    logic        deq_ready = 1'b1;
    logic [31:0] deq_ins;
    logic [31:0] deq_pc;
    logic        deq_pred_taken;
    logic [7:0]  deq_bht_id;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        pred;
        logic [7:0]  bid;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc = '0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] JAL  = 32'hFF9F_F06F;  // jal x0,-8
    localparam logic [31:0] JALR = 32'h0000_8067;  // jalr x0,0(x1)

    ins_fetch_queue #(.DEPTH(16), .BHT_IDX_W(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_done(fetch_done), .fetch_ins(fetch_ins),
        .bht_id1(bht_id1), .bht_get(bht_get),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_ins(deq_ins), .deq_pc(deq_pc),
        .deq_pred_taken(deq_pred_taken), .deq_bht_id(deq_bht_id),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consumer side: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rdy && !flush && deq_valid && deq_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_deq", 32'(deq_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deq_pc", deq_pc, e.pc);
                chk("deq_ins", deq_ins, e.ins);
                chk("deq_pred", 32'(deq_pred_taken), 32'(e.pred));
                chk("deq_bht_id", 32'(deq_bht_id), 32'(e.bid));
            end
        end
    end

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            if (fetch_req) return;
            step();
        end
        chk("fetch_req_timeout", 32'(fetch_req), 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        step();
        flush = 1'b0;
        sb.delete();
        exp_pc = target;
        chk("flush_deq_valid", 32'(deq_valid), 32'd0);
        chk("flush_req_low", 32'(fetch_req), 32'd0);
        step();
        chk("flush_req_high", 32'(fetch_req), 32'd1);
        chk("flush_fetch_pc", fetch_pc, target);
    endtask

    task automatic do_fetch(input logic [31:0] ins, input logic bht, input logic exp_pred,
                            input logic [31:0] exp_next);
        exp_t e;
        wait_req();
        chk("fetch_pc", fetch_pc, exp_pc);
        chk("bht_id1", 32'(bht_id1), 32'(exp_pc[9:2]));
        fetch_ins  = ins;
        bht_get    = bht;
        fetch_done = 1'b1;
        e.ins  = ins;
        e.pc   = exp_pc;
        e.pred = exp_pred;
        e.bid  = exp_pc[9:2];
        sb.push_back(e);
        step();
        fetch_done = 1'b0;
        exp_pc = exp_next;
        chk("next_fetch_pc", fetch_pc, exp_next);
    endtask

    task automatic drain();
        deq_ready = 1'b1;
        for (int i = 0; i < 40 && deq_valid; i++) step();
        chk("drained_valid", 32'(deq_valid), 32'd0);
        chk("drained_sb", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset: outputs quiet while rst is held, fetch_req on the 2nd cycle after release.
        repeat (3) begin
            step();
            chk("rst_req", 32'(fetch_req), 32'd0);
            chk("rst_valid", 32'(deq_valid), 32'd0);
        end
        rst = 1'b0;
        chk("rel_req_c1", 32'(fetch_req), 32'd0);
        step();
        chk("rel_req_c2", 32'(fetch_req), 32'd1);
        chk("rel_pc", fetch_pc, 32'h0);
        chk("rel_valid", 32'(deq_valid), 32'd0);

        // Branch predicted taken / not taken.
        do_flush(32'h100);
        do_fetch(BEQ, 1'b1, 1'b1, 32'h110);
        do_flush(32'h100);
        do_fetch(BEQ, 1'b0, 1'b0, 32'h104);
        // JAL backwards; JALR ignores the BHT.
        do_flush(32'h200);
        do_fetch(JAL, 1'b0, 1'b1, 32'h1F8);
        do_flush(32'h300);
        do_fetch(JALR, 1'b1, 1'b0, 32'h304);
        // Address wraps modulo 2^32.
        do_flush(32'hFFFF_FFFC);
        do_fetch(NOP, 1'b0, 1'b0, 32'h0);
        drain();

        // Fill to full with the consumer stalled.
        deq_ready = 1'b0;
        do_flush(32'h500);
        for (int i = 0; i < 16; i++) do_fetch(NOP, i[0], 1'b0, exp_pc + 32'd4);
        chk("full_req", 32'(fetch_req), 32'd0);
        chk("full_valid", 32'(deq_valid), 32'd1);
        step();
        chk("full_req_hold", 32'(fetch_req), 32'd0);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("req_after_deq_c1", 32'(fetch_req), 32'd0);
        step();
        chk("req_after_deq_c2", 32'(fetch_req), 32'd1);
        // Simultaneous enqueue and dequeue keeps 15 entries, so fetching continues.
        deq_ready = 1'b1;
        do_fetch(NOP, 1'b0, 1'b0, exp_pc + 32'd4);
        deq_ready = 1'b0;
        chk("enq_deq_req", 32'(fetch_req), 32'd1);
        do_fetch(NOP, 1'b0, 1'b0, exp_pc + 32'd4);
        chk("refull_req", 32'(fetch_req), 32'd0);
        drain();

        // Flush in the same cycle as fetch_done: the fetch is dropped.
        wait_req();
        fetch_ins  = NOP;
        fetch_done = 1'b1;
        flush      = 1'b1;
        flush_pc   = 32'h400;
        step();
        fetch_done = 1'b0;
        flush      = 1'b0;
        chk("fl_done_valid", 32'(deq_valid), 32'd0);
        chk("fl_done_req", 32'(fetch_req), 32'd0);
        step();
        chk("fl_done_req2", 32'(fetch_req), 32'd1);
        chk("fl_done_pc", fetch_pc, 32'h400);
        chk("fl_done_valid2", 32'(deq_valid), 32'd0);
        exp_pc = 32'h400;

        // rdy=0 freezes everything even with fetch_done asserted.
        wait_req();
        rdy        = 1'b0;
        fetch_ins  = NOP;
        fetch_done = 1'b1;
        repeat (3) begin
            step();
            chk("hold_pc", fetch_pc, exp_pc);
            chk("hold_req", 32'(fetch_req), 32'd1);
            chk("hold_valid", 32'(deq_valid), 32'd0);
        end
        begin
            exp_t e;
            e.ins  = NOP;
            e.pc   = exp_pc;
            e.pred = 1'b0;
            e.bid  = exp_pc[9:2];
            sb.push_back(e);
        end
        rdy = 1'b1;
        step();
        fetch_done = 1'b0;
        exp_pc = exp_pc + 32'd4;
        chk("resume_pc", fetch_pc, exp_pc);
        do_fetch(NOP, 1'b0, 1'b0, exp_pc + 32'd4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
